// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//
// Program-counter register for the IF stage of the pipelined datapath.
// The register holds a word address: byte-address bits [ADDR_W-1:2].
//
// The next fetch address comes from one of four sources:
//   - the sequential/branch NPC,
//   - the exception vector,
//   - the ERET return address,
//   - a redirect that was latched while the pipe was stalled.
//
// The PC holds while any stall source is active. An exception or ERET
// request that arrives during a stall is latched, so the redirect is not
// lost. It is applied in the first unstalled cycle.
//
// Build option:
//   PC_PERF_EN - adds saturating performance counters stall_cycles and
//                redir_count. When it is undefined, those ports do not exist.
//
// Parameters:
//   ADDR_W    - byte-address width
//   RESET_VEC - byte address loaded on Reset (bits [1:0] ignored)
//   EXC_VEC   - byte address loaded on an exception redirect
//   N_STALL   - number of independent stall sources
//
// Ports:
//   Clk           in   clock, all state updates on posedge
//   Reset         in   synchronous active-high reset
//   stall         in   [N_STALL]  stall sources, any bit high holds PC
//   npc           in   [ADDR_W-2] next sequential/branch word address
//   exc_req       in   single-cycle exception redirect request
//   eret_req      in   single-cycle ERET redirect request
//   eret_addr     in   [ADDR_W-2] ERET return word address
//   pc            out  [ADDR_W-2] current fetch word address
//   redir_pending out  a latched redirect waits for the stall to clear
//   pc_advanced   out  high for one cycle after a cycle that updated PC
//   stall_cycles  out  [32] stalled-cycle counter     (PC_PERF_EN only)
//   redir_count   out  [16] applied-redirect counter  (PC_PERF_EN only)
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 'h0000_0034,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 'h0000_4180,
    parameter int unsigned       N_STALL   = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [N_STALL-1:0]  stall,
    input  logic [ADDR_W-3:0]   npc,
    input  logic                exc_req,
    input  logic                eret_req,
    input  logic [ADDR_W-3:0]   eret_addr,
    output logic [ADDR_W-3:0]   pc,
    output logic                redir_pending,
`ifdef PC_PERF_EN
    output logic [31:0]         stall_cycles,
    output logic [15:0]         redir_count,
`endif
    output logic                pc_advanced
);

    localparam int unsigned     WA_W     = ADDR_W - 2;
    localparam logic [WA_W-1:0] RESET_WA = RESET_VEC[ADDR_W-1:2];
    localparam logic [WA_W-1:0] EXC_WA   = EXC_VEC[ADDR_W-1:2];

    // Architectural state
    logic [WA_W-1:0] pc_q,        pc_d;
    logic            pend_exc_q,  pend_exc_d;
    logic            pend_eret_q, pend_eret_d;
    logic [WA_W-1:0] pend_addr_q, pend_addr_d;
    logic            pc_adv_q,    pc_adv_d;

    logic stalled;
    logic redir_applied;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        stalled       = |stall;
        pc_d          = pc_q;
        pend_exc_d    = pend_exc_q;
        pend_eret_d   = pend_eret_q;
        pend_addr_d   = pend_addr_q;
        pc_adv_d      = ~stalled;
        redir_applied = 1'b0;

        if (stalled) begin
            // An exception replaces a pending ERET. A later ERET never
            // replaces a pending exception.
            if (exc_req) begin
                pend_exc_d  = 1'b1;
                pend_eret_d = 1'b0;
            end else if (eret_req && !pend_exc_q) begin
                pend_eret_d = 1'b1;
                pend_addr_d = eret_addr;
            end
        end else begin
            // Priority: exception (live or latched), then live ERET, then
            // latched ERET, then NPC. A live ERET wins over a latched one
            // because it carries the more recent return address.
            if (exc_req || pend_exc_q) begin
                pc_d          = EXC_WA;
                redir_applied = 1'b1;
            end else if (eret_req) begin
                pc_d          = eret_addr;
                redir_applied = 1'b1;
            end else if (pend_eret_q) begin
                pc_d          = pend_addr_q;
                redir_applied = 1'b1;
            end else begin
                pc_d          = npc;
            end
            pend_exc_d  = 1'b0;
            pend_eret_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q        <= RESET_WA;
            pend_exc_q  <= 1'b0;
            pend_eret_q <= 1'b0;
            pend_addr_q <= '0;
            pc_adv_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pend_exc_q  <= pend_exc_d;
            pend_eret_q <= pend_eret_d;
            pend_addr_q <= pend_addr_d;
            pc_adv_q    <= pc_adv_d;
        end
    end

    assign pc            = pc_q;
    assign redir_pending = pend_exc_q | pend_eret_q;
    assign pc_advanced   = pc_adv_q;

`ifdef PC_PERF_EN
    // -----------------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------------
    logic [31:0] stall_cycles_q;
    logic [15:0] redir_count_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cycles_q <= '0;
            redir_count_q  <= '0;
        end else begin
            if (stalled && (stall_cycles_q != '1))
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if (redir_applied && (redir_count_q != '1))
                redir_count_q <= redir_count_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign redir_count  = redir_count_q;
`else
    // The redirect strobe only feeds the counters.
    logic unused_redir;
    assign unused_redir = redir_applied;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//
// Scoreboard bench for pc_unit.
//
// The driver applies one set of inputs per cycle on the falling edge. For
// each set it updates a reference model and pushes the expected post-edge
// outputs into a queue. The monitor pops one entry after every rising edge
// and compares it with the DUT outputs.
//
// The reference model tracks the pending redirect as a single "kind" value
// (none / exception / eret) and computes the target directly from the
// redirect rules.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam int unsigned AW  = 32;
    localparam int unsigned WAW = AW - 2;
    localparam int unsigned NS  = 3;
    localparam logic [WAW-1:0] RESET_WA = 30'h0D;
    localparam logic [WAW-1:0] EXC_WA   = 30'h1060;

    logic           Clk = 1'b0;
    logic           Reset;
    logic [NS-1:0]  stall;
    logic [WAW-1:0] npc;
    logic           exc_req;
    logic           eret_req;
    logic [WAW-1:0] eret_addr;
    logic [WAW-1:0] pc;
    logic           redir_pending;
    logic           pc_advanced;
`ifdef PC_PERF_EN
    logic [31:0]    stall_cycles;
    logic [15:0]    redir_count;
`endif

    pc_unit #(
        .ADDR_W    (AW),
        .RESET_VEC (32'h0000_0034),
        .EXC_VEC   (32'h0000_4180),
        .N_STALL   (NS)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .stall         (stall),
        .npc           (npc),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .eret_addr     (eret_addr),
        .pc            (pc),
        .redir_pending (redir_pending),
`ifdef PC_PERF_EN
        .stall_cycles  (stall_cycles),
        .redir_count   (redir_count),
`endif
        .pc_advanced   (pc_advanced)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [WAW-1:0] pc;
        logic           pend;
        logic           adv;
        logic [31:0]    stc;
        logic [15:0]    rdc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model state
    localparam int PK_NONE = 0;
    localparam int PK_EXC  = 1;
    localparam int PK_ERET = 2;
    logic [WAW-1:0] m_pc;
    int             m_kind;
    logic [WAW-1:0] m_addr;
    logic           m_adv;
    longint         m_stc;
    longint         m_rdc;

    task automatic model_step(input logic rst, input logic [NS-1:0] st,
                              input logic [WAW-1:0] n, input logic ex,
                              input logic er, input logic [WAW-1:0] ea);
        exp_t e;
        if (rst) begin
            m_pc   = RESET_WA;
            m_kind = PK_NONE;
            m_adv  = 1'b0;
            m_stc  = 0;
            m_rdc  = 0;
        end else if (st != '0) begin
            if (ex)
                m_kind = PK_EXC;
            else if (er && m_kind != PK_EXC) begin
                m_kind = PK_ERET;
                m_addr = ea;
            end
            m_adv = 1'b0;
            if (m_stc < 64'hFFFF_FFFF) m_stc++;
        end else begin
            if (ex || m_kind == PK_EXC || er || m_kind == PK_ERET)
                if (m_rdc < 65535) m_rdc++;
            if (ex || m_kind == PK_EXC) m_pc = EXC_WA;
            else if (er)                m_pc = ea;
            else if (m_kind == PK_ERET) m_pc = m_addr;
            else                        m_pc = n;
            m_kind = PK_NONE;
            m_adv  = 1'b1;
        end
        e.pc   = m_pc;
        e.pend = (m_kind != PK_NONE);
        e.adv  = m_adv;
        e.stc  = m_stc[31:0];
        e.rdc  = m_rdc[15:0];
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs on the falling edge and record the expectation.
    task automatic cycle(input logic rst, input logic [NS-1:0] st,
                         input logic [WAW-1:0] n, input logic ex,
                         input logic er, input logic [WAW-1:0] ea);
        @(negedge Clk);
        Reset     = rst;
        stall     = st;
        npc       = n;
        exc_req   = ex;
        eret_req  = er;
        eret_addr = ea;
        model_step(rst, st, n, ex, er, ea);
    endtask

    // Monitor: the DUT presents a fresh PC after every rising edge.
    always @(posedge Clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cyc++;
            checks++;
            if (pc !== e.pc) begin
                errors++;
                $display("FAIL pc cyc=%0d actual=%h required=%h", cyc, pc, e.pc);
            end
            checks++;
            if (redir_pending !== e.pend) begin
                errors++;
                $display("FAIL redir_pending cyc=%0d actual=%b required=%b",
                         cyc, redir_pending, e.pend);
            end
            checks++;
            if (pc_advanced !== e.adv) begin
                errors++;
                $display("FAIL pc_advanced cyc=%0d actual=%b required=%b",
                         cyc, pc_advanced, e.adv);
            end
`ifdef PC_PERF_EN
            checks++;
            if (stall_cycles !== e.stc) begin
                errors++;
                $display("FAIL stall_cycles cyc=%0d actual=%0d required=%0d",
                         cyc, stall_cycles, e.stc);
            end
            checks++;
            if (redir_count !== e.rdc) begin
                errors++;
                $display("FAIL redir_count cyc=%0d actual=%0d required=%0d",
                         cyc, redir_count, e.rdc);
            end
`endif
        end
    end

    initial begin
        Reset = 1'b1; stall = '0; npc = '0; exc_req = 1'b0;
        eret_req = 1'b0; eret_addr = '0;
        m_pc = '0; m_kind = PK_NONE; m_addr = '0; m_adv = 1'b0;
        m_stc = 0; m_rdc = 0;

        // Reset while every stall source is active, then release.
        cycle(1, 3'b111, 30'h0,  0, 0, 30'h0);
        cycle(0, 3'b000, 30'h0E, 0, 0, 30'h0);
        cycle(0, 3'b000, 30'h0E, 0, 0, 30'h0);

        // Hold under a single stall source while NPC changes.
        cycle(0, 3'b010, 30'h20, 0, 0, 30'h0);
        cycle(0, 3'b010, 30'h21, 0, 0, 30'h0);
        cycle(0, 3'b010, 30'h22, 0, 0, 30'h0);
        cycle(0, 3'b000, 30'h23, 0, 0, 30'h0);

        // Exception latched during a stall, applied after the release.
        cycle(0, 3'b001, 30'h30, 1, 0, 30'h0);
        cycle(0, 3'b001, 30'h31, 0, 0, 30'h0);
        cycle(0, 3'b001, 30'h32, 0, 0, 30'h0);
        cycle(0, 3'b000, 30'h33, 0, 0, 30'h0);
        cycle(0, 3'b000, 30'h34, 0, 0, 30'h0);

        // ERET then exception during a stall: the exception wins.
        cycle(0, 3'b100, 30'h40, 0, 1, 30'h100);
        cycle(0, 3'b100, 30'h41, 0, 0, 30'h0);
        cycle(0, 3'b100, 30'h42, 1, 0, 30'h0);
        cycle(0, 3'b000, 30'h43, 0, 0, 30'h0);
        // Exception then ERET during a stall: the exception is kept.
        cycle(0, 3'b100, 30'h50, 1, 0, 30'h0);
        cycle(0, 3'b100, 30'h51, 0, 1, 30'h100);
        cycle(0, 3'b000, 30'h52, 0, 0, 30'h0);
        // A latched ERET alone is applied on release.
        cycle(0, 3'b011, 30'h58, 0, 1, 30'h155);
        cycle(0, 3'b000, 30'h59, 0, 0, 30'h0);

        // Simultaneous live requests, then a live ERET alone.
        cycle(0, 3'b000, 30'h60, 1, 1, 30'h300);
        cycle(0, 3'b000, 30'h61, 0, 1, 30'h200);

        // Reset discards a pending exception while still stalled.
        cycle(0, 3'b001, 30'h70, 1, 0, 30'h0);
        cycle(1, 3'b001, 30'h71, 0, 0, 30'h0);
        cycle(0, 3'b001, 30'h72, 0, 0, 30'h0);
        cycle(0, 3'b000, 30'h73, 0, 0, 30'h0);

        // Randomised traffic, including wide NPC/return-address values.
        for (int i = 0; i < 400; i++) begin
            logic [NS-1:0]  st;
            logic [WAW-1:0] n, ea;
            logic           rst, ex, er;
            st  = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
            n   = WAW'($urandom);
            ea  = WAW'($urandom);
            ex  = ($urandom_range(0, 7) == 0);
            er  = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 63) == 0);
            cycle(rst, st, n, ex, er, ea);
        end

        // Let the monitor drain; an undrained queue counts as a failure.
        for (int w = 0; w < 10 && exp_q.size() != 0; w++)
            @(posedge Clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
